// File: rtl/henon_result_uart_tx.sv
// henon_result_uart_tx
//
// Return-path UART transmitter for the Henon PRNG. When the PRNG core pulses
// result_valid, the X/Y result pair is captured and sent to the host as a
// 10-byte packet on an 8N1 line:
//   HEADER_BYTE, x[31:24], x[23:16], x[15:8], x[7:0],
//   y[31:24], y[23:16], y[15:8], y[7:0], checksum (XOR of the 8 data bytes).
// Bytes are sent back to back, with no idle bit-times between them.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous, active-high reset
//   result_valid single-cycle pulse; random_in_x/y are valid in that cycle
//   random_in_x  PRNG X result (32 bits)
//   random_in_y  PRNG Y result (32 bits)
//   tx_serial    UART line, idle high
//   busy         high while a packet is in flight
//   tx_done      one-cycle pulse after the last stop bit has completed
module henon_result_uart_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        result_valid,
  input  logic [31:0] random_in_x,
  input  logic [31:0] random_in_y,
  output logic        tx_serial,
  output logic        busy,
  output logic        tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BYTE = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DONE
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [3:0]        byte_idx;
  logic [7:0]        shreg;
  logic [31:0]       x_lat;
  logic [31:0]       y_lat;
  logic [7:0]        csum;

  logic baud_end;
  assign baud_end = (baud_cnt == BAUD_LAST);

  function automatic logic [7:0] xor_bytes(input logic [31:0] x, input logic [31:0] y);
    return x[31:24] ^ x[23:16] ^ x[15:8] ^ x[7:0] ^
           y[31:24] ^ y[23:16] ^ y[15:8] ^ y[7:0];
  endfunction

  // Byte idx of the packet being sent; index 0 (header) is loaded at accept.
  function automatic logic [7:0] pkt_byte(input logic [3:0]  idx,
                                          input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic [7:0]  c);
    logic [7:0] b;
    case (idx)
      4'd0:    b = HEADER_BYTE;
      4'd1:    b = x[31:24];
      4'd2:    b = x[23:16];
      4'd3:    b = x[15:8];
      4'd4:    b = x[7:0];
      4'd5:    b = y[31:24];
      4'd6:    b = y[23:16];
      4'd7:    b = y[15:8];
      4'd8:    b = y[7:0];
      default: b = c;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      x_lat     <= '0;
      y_lat     <= '0;
      csum      <= '0;
      tx_serial <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        // DONE behaves like IDLE for acceptance, so a result arriving in the
        // tx_done cycle starts the next packet after exactly one idle clock.
        IDLE, DONE: begin
          tx_serial <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
          if (result_valid) begin
            x_lat     <= random_in_x;
            y_lat     <= random_in_y;
            csum      <= xor_bytes(random_in_x, random_in_y);
            shreg     <= HEADER_BYTE;
            byte_idx  <= '0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
            tx_serial <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end

        START: begin
          if (baud_end) begin
            baud_cnt  <= '0;
            tx_serial <= shreg[0];
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt   <= '0;
              tx_serial <= 1'b1;
              state     <= STOP;
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shreg     <= {1'b0, shreg[7:1]};
              tx_serial <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (byte_idx == LAST_BYTE) begin
              tx_serial <= 1'b1;
              busy      <= 1'b0;
              tx_done   <= 1'b1;
              state     <= DONE;
            end else begin
              byte_idx  <= byte_idx + 1'b1;
              shreg     <= pkt_byte(byte_idx + 4'd1, x_lat, y_lat, csum);
              tx_serial <= 1'b0;
              state     <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: begin
          tx_serial <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_henon_result_uart_tx.sv
module tb_henon_result_uart_tx;

  localparam int CPB = 4;

  logic        clk;
  logic        rst;
  logic        result_valid;
  logic [31:0] random_in_x;
  logic [31:0] random_in_y;
  logic        tx_serial;
  logic        busy;
  logic        tx_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  bit         abort_rx = 0;

  henon_result_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .HEADER_BYTE (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .result_valid(result_valid),
    .random_in_x (random_in_x),
    .random_in_y (random_in_y),
    .tx_serial   (tx_serial),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; pulses result_valid for one cycle and queues
  // the packet the host should receive. Returns at the first line cycle.
  task automatic send(input logic [31:0] x, input logic [31:0] y);
    logic [7:0] c;
    c = 8'h00;
    exp_q.push_back(8'hA5);
    for (int b = 3; b >= 0; b--) begin
      exp_q.push_back(x[b*8 +: 8]);
      c = c ^ x[b*8 +: 8];
    end
    for (int b = 3; b >= 0; b--) begin
      exp_q.push_back(y[b*8 +: 8]);
      c = c ^ y[b*8 +: 8];
    end
    exp_q.push_back(c);
    result_valid = 1'b1;
    random_in_x  = x;
    random_in_y  = y;
    @(negedge clk);
    result_valid = 1'b0;
    check_eq("start_latency", tx_serial, 1'b0);
    check_eq("busy_on", busy, 1'b1);
  endtask

  // Runs from the first line cycle (k=1) to the tx_done cycle.
  task automatic wait_done(input int stray_at, input bit scramble);
    int k;
    k = 1;
    while (tx_done !== 1'b1 && k < 1000) begin
      result_valid = (k == stray_at);
      if (k == stray_at) random_in_x = 32'h11111111;
      if (scramble) begin
        random_in_x = $urandom;
        random_in_y = $urandom;
      end
      @(negedge clk);
      k++;
    end
    result_valid = 1'b0;
    check_eq("done_latency", k, 401);
    check_eq("done_busy", busy, 1'b0);
    check_eq("done_line", tx_serial, 1'b1);
  endtask

  task automatic idle_watch(input int cycles, input string tag);
    int extra;
    extra = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || tx_serial !== 1'b1 || busy !== 1'b0) extra++;
    end
    check_eq(tag, extra, 0);
  endtask

  // Line decoder: samples every cycle of every bit so bit width is checked too.
  logic [9:0] rx_bits;
  int         rx_bad;
  bit         rx_ab;
  logic [7:0] rx_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && !abort_rx && tx_serial === 1'b0) begin
        rx_bad = 0;
        rx_ab  = 0;
        for (int b = 0; b < 10; b++) begin
          for (int s = 0; s < CPB; s++) begin
            if (!(b == 0 && s == 0)) @(negedge clk);
            if (abort_rx) rx_ab = 1;
            if (s == 0) rx_bits[b] = tx_serial;
            else if (tx_serial !== rx_bits[b]) rx_bad++;
          end
        end
        if (!rx_ab) begin
          check_eq("bit_width", rx_bad, 0);
          check_eq("stop_bit", rx_bits[9], 1'b1);
          if (exp_q.size() == 0) begin
            check_eq("unexpected_byte", {24'h0, rx_bits[8:1]}, 32'hFFFFFFFF);
          end else begin
            rx_exp = exp_q.pop_front();
            check_eq("rx_byte", rx_bits[8:1], rx_exp);
          end
        end
      end
    end
  end

  initial begin
    int k;
    rst          = 1'b1;
    result_valid = 1'b0;
    random_in_x  = '0;
    random_in_y  = '0;

    // Reset hold with result_valid toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("rst_line", tx_serial, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", tx_done, 1'b0);
      result_valid = ~result_valid;
      random_in_x  = 32'hFFFF0000 + i;
    end
    rst          = 1'b0;
    result_valid = 1'b0;
    idle_watch(20, "post_reset_idle");

    // Single packet
    send(32'hDEADBEEF, 32'h00000000);
    wait_done(0, 0);
    idle_watch(5, "idle_after_pkt1");

    // Busy ignore: stray result 50 cycles in
    send(32'hCAFEF00D, 32'h0BADC0DE);
    wait_done(50, 0);
    idle_watch(100, "no_second_packet");

    // Back-to-back, with inputs scrambled every cycle after accept
    send(32'h00000000, 32'hFFFFFFFF);
    wait_done(0, 0);
    send(32'h12345678, 32'h9ABCDEF0);
    wait_done(0, 1);
    idle_watch(5, "idle_after_b2b");

    // Mid-packet reset at cycle 120
    send(32'hA1B2C3D4, 32'h5E6F7081);
    k = 1;
    while (k < 120) begin
      @(negedge clk);
      k++;
    end
    rst      = 1'b1;
    abort_rx = 1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_line", tx_serial, 1'b1);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_done", tx_done, 1'b0);
    idle_watch(300, "midrst_quiet");
    exp_q.delete();
    abort_rx = 0;
    send(32'h0F1E2D3C, 32'h4B5A6978);
    wait_done(0, 0);

    idle_watch(50, "final_idle");
    check_eq("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/henon_result_uart_tx.md
Name: henon_result_uart_tx

Overview:
Return-path UART transmitter for the Henon PRNG.
- Captures one random_out_x / random_out_y result pair when the PRNG core pulses done.
- Serialises the pair to the host as a framed, checksummed 10-byte packet on a single 8N1 UART line.
- Sits beside henon_prng_top: the UART receive side feeds pixels in, this block sends results out.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
HEADER_BYTE, 8'hA5, sync byte sent first in every packet.

Ports:
clk  input  1  system clock, all logic rising-edge.
rst  input  1  synchronous, active-high reset.
result_valid  input  1  single-cycle pulse; random_in_x/y valid in that cycle.
random_in_x  input  32  PRNG X result.
random_in_y  input  32  PRNG Y result.
tx_serial  output  1  UART line, idle high.
busy  output  1  high while a packet is in flight.
tx_done  output  1  one-cycle pulse when the last stop bit has completed.

Behaviour:
- Reset values:
  - tx_serial=1, busy=0, tx_done=0.
  - Internal shift register, bit counter, byte index, baud counter and checksum all cleared.
  - State = IDLE.
- Accept rule: result_valid is sampled only while busy=0; it is ignored (no queueing) while busy=1.
- On accept:
  - x and y are latched.
  - Checksum = XOR of the 8 data bytes.
  - busy=1 from the next cycle.
- Packet order:
  - HEADER_BYTE.
  - x[31:24], x[23:16], x[15:8], x[7:0].
  - y[31:24] … y[7:0].
  - Checksum byte.
  - Total 10 bytes.
- Byte framing (8N1): start bit 0, data bits LSB first, stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles.
- Latency: tx_serial falls to 0 in the cycle after the accept cycle. There are no idle bit-times between bytes; each start bit immediately follows the previous stop bit.
- Packet duration: 100*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the last stop bit.
- FSM states:
  - IDLE → START (on accept).
  - START → DATA (after CLKS_PER_BIT cycles).
  - DATA → STOP (after 8 bits).
  - STOP → START (if byte index < 9, index++).
  - STOP → DONE (if byte index = 9).
  - DONE → IDLE (after one cycle).
- DONE cycle: tx_done=1, busy=0, tx_serial=1. A result_valid arriving in the DONE cycle is accepted, giving back-to-back packets separated by exactly one idle clock.
- Baud counter counts 0..CLKS_PER_BIT-1 and resets at every bit boundary. The bit counter wraps 7→0 at the end of DATA.
- rst mid-packet: on the next edge tx_serial=1, busy=0, state=IDLE, and the partial packet is abandoned (the host detects it via a missing header/checksum). tx_done is not pulsed.
- result_valid and rst high in the same cycle: reset wins; nothing is latched.
- Inputs are not sampled after the accept cycle; random_in_x/y may change freely during transmission.

Test Plan:
(All with CLKS_PER_BIT=4.)
1. Reset hold:
   - Stimulus: rst=1 for 3 cycles with result_valid toggling.
   - Required: tx_serial=1, busy=0, tx_done=0 throughout and after release.
2. Single packet:
   - Stimulus: x=32'hDEADBEEF, y=32'h00000000, one-cycle result_valid.
   - Required: line decodes to A5 DE AD BE EF 00 00 00 00 22.
   - Required: start bit begins 1 cycle after the pulse; each bit lasts 4 cycles; tx_done pulses exactly 401 cycles after the accept cycle.
3. Busy ignore:
   - Stimulus: second result_valid (x=32'h11111111) 50 cycles into packet 2.
   - Required: packet 2 content unchanged; no second packet follows; a single tx_done.
4. Back-to-back:
   - Stimulus: result_valid asserted in the tx_done cycle with x=32'h12345678, y=32'h9ABCDEF0.
   - Required: next start bit 1 cycle later; bytes A5 12 34 56 78 9A BC DE F0 00.
5. Mid-packet reset:
   - Stimulus: rst pulse at cycle 120 of a packet.
   - Required: tx_serial=1 and busy=0 on the next edge; no tx_done; a fresh result_valid afterwards sends a complete correct packet.
6. Input stability:
   - Stimulus: change random_in_x/y every cycle after accept.
   - Required: transmitted bytes equal the values latched in the accept cycle.
